mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-requester arbiter for the single shared memory port.
- Requester 0 is the multicycle CPU core; requester 1 is a DMA/boot-loader master.
- Forwards one word/half/byte access per accepted request to the synchronous memory; the memory has 1-cycle read latency and byte-masked writes.
- Returns read data to the owning requester with a valid strobe.

Parameters:
- MAX_HOLD, 8: maximum consecutive grants to one requester while the other is requesting; range 1..255.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_i  in  2  per-requester access request; bit0 = CPU, bit1 = DMA
- addr_i  in  2xADDR_W  per-requester byte address
- wdata_i  in  2x32  per-requester write data, already byte-lane aligned and big-endian swapped
- bmask_i  in  2x4  per-requester byte mask (1000 = lane 0)
- we_i  in  2  per-requester write enable
- gnt_o  out  2  one-hot accept strobe; a request is consumed in the cycle req_i[n] && gnt_o[n]
- rvalid_o  out  2  read-data-valid strobe per requester
- rdata_o  out  32  read data, shared; valid only when an rvalid_o bit is high
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  32  memory write data
- mem_bmask_o  out  4  memory byte mask
- mem_we_o  out  1  memory write strobe
- mem_rdata_i  in  32  memory read data, valid 1 cycle after the address

Behaviour:
- Reset values (asynchronous):
  - gnt_o = 0, rvalid_o = 0, mem_we_o = 0, mem_bmask_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - last_owner = 1, so the CPU wins the first tie.
  - hold_cnt = 0, state = IDLE.
- States:
  - IDLE: no access in flight. If any req_i bit is set, select a winner and assert gnt_o combinationally in the same cycle. The winner's addr/wdata/bmask/we are registered onto the mem_* outputs at the clock edge.
  - ISSUE: mem_* driven for exactly one cycle. A write asserts mem_we_o here. A read latches owner into rd_owner.
    - Read → RESP.
    - Write → IDLE.
  - RESP: rdata_o = mem_rdata_i and rvalid_o[rd_owner] = 1 for one cycle. Next state is always IDLE; no request is accepted in RESP.
- Latency:
  - Write: gnt cycle + 1 memory cycle.
  - Read: gnt at T, mem address at T+1, rvalid at T+2.
  - Maximum throughput is one access per 2 cycles (write) or 3 cycles (read).
- gnt_o is asserted only in IDLE, is never asserted for an unrequested bit, and is never two-hot.
- Arbitration:
  - One requester only: that requester wins.
  - Both requesting: the requester other than last_owner wins (round-robin).
  - Override: if last_owner won the previous grant, hold_cnt < MAX_HOLD, and the other requester was idle at that grant, last_owner may win again. This gives CPU fetch/data pairs back-to-back access while DMA is silent.
  - Same-owner grants increment hold_cnt, saturating at MAX_HOLD. A grant to the other owner resets it to 1.
  - At MAX_HOLD with the other requesting, the other requester must win.
- mem_we_o is low in every state except ISSUE-write.
- mem_bmask_o = 0 outside ISSUE, so an idle bus never writes.
- Requesters hold req_i and payload stable until granted. A req_i drop before grant is legal and is simply not serviced.
- Reset mid-operation: the in-flight access is abandoned, no rvalid_o is produced, and outputs take their reset values immediately.
- A write in ISSUE followed by a read to the same address returns the new data; the memory is write-first.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds output stat_grants_o (2x16): saturating grant counters per requester.
  - Adds output stat_wait_o (16): saturating count of cycles where a req_i bit was high but not granted.
  - All counters clear on reset.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_bus_pkg:
  - typedef arb_state_t {IDLE, ISSUE, RESP}.
  - Requester index constants REQ_CPU = 0, REQ_DMA = 1.
  - Byte-mask constants BMASK_WORD = 4'b1111, BMASK_NONE = 4'b0000.
- One natural sub-module: rr_pick2. A combinational winner selector with inputs req, last_owner, hold_cnt, and MAX_HOLD, and a one-hot winner output. It is instantiated once.

Test Plan:
- CPU-only read at addr 0x10, memory returns 0xDEADBEEF → gnt_o = 01 at T, mem_addr_o = 0x10 at T+1, rvalid_o = 01 with rdata_o = 0xDEADBEEF at T+2.
- DMA write 0x12345678 to 0x20 with bmask 0011 → mem_we_o = 1 for one cycle with mem_bmask_o = 0011; a following CPU read of 0x20 returns the merged word.
- Both requesting continuously, MAX_HOLD = 8, last_owner = CPU → grants alternate DMA, CPU, DMA …; no requester waits more than one grant.
- DMA idle, CPU issues 20 back-to-back reads; DMA raises req at CPU grant #3 → CPU keeps grants only while hold_cnt < 8; DMA is granted no later than the 8th consecutive CPU grant.
- Reset asserted during RESP of a CPU read → no rvalid_o, all outputs 0 asynchronously; after release, the first tie goes to the CPU.
- With ARB_STATS_EN, 5 CPU and 3 DMA accesses with one tie → stat_grants_o = {3, 5} and stat_wait_o ≥ 1; with the macro undefined, the design compiles with the ports absent.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;

    localparam logic [3:0] BMASK_WORD = 4'b1111;
    localparam logic [3:0] BMASK_NONE = 4'b0000;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin winner select with bounded hold-over
module rr_pick2
    import mem_bus_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic [7:0] hold_cnt,
    input  logic       other_idle,
    output logic [1:0] winner
);

    logic [1:0] last_oh;
    logic [1:0] other_oh;
    logic       keep_last;

    assign last_oh  = last_owner ? 2'b10 : 2'b01;
    assign other_oh = last_owner ? 2'b01 : 2'b10;

    // The previous owner may repeat only if its rival was silent at that grant.
    assign keep_last = other_idle && (hold_cnt < 8'(MAX_HOLD));

    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = keep_last ? last_oh : other_oh;
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/DMA arbiter for the shared synchronous memory port
// Optional grant/wait statistics counters when ARB_STATS_EN is defined.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int ADDR_W   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_i,
    input  logic [1:0][ADDR_W-1:0] addr_i,
    input  logic [1:0][31:0]       wdata_i,
    input  logic [1:0][3:0]        bmask_i,
    input  logic [1:0]             we_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             rvalid_o,
    output logic [31:0]            rdata_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    output logic [3:0]             mem_bmask_o,
    output logic                   mem_we_o,
`ifdef ARB_STATS_EN
    output logic [1:0][15:0]       stat_grants_o,
    output logic [15:0]            stat_wait_o,
`endif
    input  logic [31:0]            mem_rdata_i
);

    arb_state_t        state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic              other_idle_q, other_idle_d;
    logic              rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_bmask_q, mem_bmask_d;
    logic              mem_we_q, mem_we_d;
    logic [1:0]        idle_req;
    logic [1:0]        winner;
    logic              win_idx;

    assign idle_req = (state_q == IDLE) ? req_i : 2'b00;
    assign win_idx  = winner[1];

    rr_pick2 #(.MAX_HOLD(MAX_HOLD)) u_pick (
        .req        (idle_req),
        .last_owner (last_owner_q),
        .hold_cnt   (hold_cnt_q),
        .other_idle (other_idle_q),
        .winner     (winner)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        other_idle_d = other_idle_q;
        rd_owner_d   = rd_owner_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_bmask_d  = mem_bmask_q;
        mem_we_d     = mem_we_q;
        case (state_q)
            IDLE: begin
                if (winner != 2'b00) begin
                    state_d      = ISSUE;
                    mem_addr_d   = addr_i[win_idx];
                    mem_wdata_d  = wdata_i[win_idx];
                    mem_bmask_d  = bmask_i[win_idx];
                    mem_we_d     = we_i[win_idx];
                    last_owner_d = win_idx;
                    other_idle_d = ~req_i[~win_idx];
                    if (win_idx != last_owner_q)
                        hold_cnt_d = 8'd1;
                    else if (hold_cnt_q < 8'(MAX_HOLD))
                        hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ISSUE: begin
                mem_we_d    = 1'b0;
                mem_bmask_d = BMASK_NONE;
                if (mem_we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d    = RESP;
                    rd_owner_d = last_owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= 8'd0;
            other_idle_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_bmask_q  <= BMASK_NONE;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            other_idle_q <= other_idle_d;
            rd_owner_q   <= rd_owner_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_bmask_q  <= mem_bmask_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign gnt_o       = winner;
    assign rvalid_o    = (state_q != RESP) ? 2'b00 : (rd_owner_q ? 2'b10 : 2'b01);
    assign rdata_o     = (state_q == RESP) ? mem_rdata_i : 32'd0;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_bmask_o = mem_bmask_q;
    assign mem_we_o    = mem_we_q;

`ifdef ARB_STATS_EN
    logic [1:0][15:0] stat_grants_q, stat_grants_d;
    logic [15:0]      stat_wait_q, stat_wait_d;

    always_comb begin
        stat_grants_d = stat_grants_q;
        stat_wait_d   = stat_wait_q;
        for (int n = 0; n < 2; n++) begin
            if (gnt_o[n] && stat_grants_q[n] != 16'hFFFF)
                stat_grants_d[n] = stat_grants_q[n] + 16'd1;
        end
        if ((req_i & ~gnt_o) != 2'b00 && stat_wait_q != 16'hFFFF)
            stat_wait_d = stat_wait_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_grants_q <= '0;
            stat_wait_q   <= '0;
        end else begin
            stat_grants_q <= stat_grants_d;
            stat_wait_q   <= stat_wait_d;
        end
    end

    assign stat_grants_o = stat_grants_q;
    assign stat_wait_o   = stat_wait_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_i;
    logic [1:0][31:0] addr_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0][3:0]  bmask_i;
    logic [1:0]       we_i;
    logic [1:0]       gnt_o;
    logic [1:0]       rvalid_o;
    logic [31:0]      rdata_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic [3:0]       mem_bmask_o;
    logic             mem_we_o;
    logic [31:0]      mem_rdata_i;
`ifdef ARB_STATS_EN
    logic [1:0][15:0] stat_grants_o;
    logic [15:0]      stat_wait_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_HOLD(8), .ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .bmask_i     (bmask_i),
        .we_i        (we_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_bmask_o (mem_bmask_o),
        .mem_we_o    (mem_we_o),
`ifdef ARB_STATS_EN
        .stat_grants_o (stat_grants_o),
        .stat_wait_o   (stat_wait_o),
`endif
        .mem_rdata_i (mem_rdata_i)
    );

    // Write-first synchronous memory; mask bit 3 selects lane 0 = bits 31:24.
    always @(posedge clk) begin
        logic [31:0] w;
        w = mem[mem_addr_o[7:2]];
        if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_bmask_o[3-b]) w[31-8*b -: 8] = mem_wdata_o[31-8*b -: 8];
            mem[mem_addr_o[7:2]] <= w;
        end
        mem_rdata_i <= w;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input logic [1:0] exp, input string tag);
        logic [1:0] g;
        bit found;
        g = 2'b00;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (gnt_o != 2'b00) begin
                g = gnt_o;
                found = 1'b1;
            end
        end
        check(tag, 32'(g), 32'(exp));
    endtask

    task automatic do_reset();
        req_i = 2'b00;
        we_i  = 2'b00;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'hAABBCCDD;
        reset = 1'b1; req_i = 2'b00; we_i = 2'b00;
        addr_i = '0; wdata_i = '0; bmask_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        check("rst_we", 32'(mem_we_o), 32'h0);
        check("rst_bmask", 32'(mem_bmask_o), 32'h0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_wdata", mem_wdata_o, 32'h0);
        @(negedge clk) reset = 1'b0;

        // CPU read of 0x10
        addr_i[0] = 32'h10; req_i = 2'b01;
        #1 check("rd_gnt", 32'(gnt_o), 32'h1);
        @(posedge clk); #1 req_i = 2'b00;
        @(negedge clk);
        check("rd_addr", mem_addr_o, 32'h10);
        check("rd_we", 32'(mem_we_o), 32'h0);
        check("rd_nogrant_issue", 32'(gnt_o), 32'h0);
        @(negedge clk);
        check("rd_rvalid", 32'(rvalid_o), 32'h1);
        check("rd_data", rdata_o, 32'hDEADBEEF);
        @(negedge clk);
        check("rd_rvalid_done", 32'(rvalid_o), 32'h0);

        // DMA byte-masked write to 0x20, then CPU reads merged word
        addr_i[1] = 32'h20; wdata_i[1] = 32'h12345678; bmask_i[1] = 4'b0011;
        we_i[1] = 1'b1; req_i = 2'b10;
        #1 check("wr_gnt", 32'(gnt_o), 32'h2);
        @(posedge clk); #1 req_i = 2'b00; we_i = 2'b00;
        @(negedge clk);
        check("wr_we", 32'(mem_we_o), 32'h1);
        check("wr_bmask", 32'(mem_bmask_o), 32'h3);
        check("wr_wdata", mem_wdata_o, 32'h12345678);
        check("wr_addr", mem_addr_o, 32'h20);
        @(negedge clk);
        check("wr_we_off", 32'(mem_we_o), 32'h0);
        check("wr_bmask_off", 32'(mem_bmask_o), 32'h0);
        addr_i[0] = 32'h20; req_i = 2'b01;
        #1 check("rdback_gnt", 32'(gnt_o), 32'h1);
        @(posedge clk); #1 req_i = 2'b00;
        @(negedge clk); @(negedge clk);
        check("rdback_rvalid", 32'(rvalid_o), 32'h1);
        check("rdback_data", rdata_o, 32'hAABB5678);

        // Reset during RESP of a CPU read
        @(negedge clk);
        addr_i[0] = 32'h10; req_i = 2'b01;
        #1 check("rr_gnt", 32'(gnt_o), 32'h1);
        @(posedge clk); #1 req_i = 2'b00;
        @(posedge clk); #2;
        check("rr_in_resp", 32'(rvalid_o), 32'h1);
        reset = 1'b1;
        #1;
        check("rr_rvalid", 32'(rvalid_o), 32'h0);
        check("rr_addr", mem_addr_o, 32'h0);
        check("rr_we", 32'(mem_we_o), 32'h0);
        check("rr_bmask", 32'(mem_bmask_o), 32'h0);
        check("rr_gnt_off", 32'(gnt_o), 32'h0);
        @(negedge clk) reset = 1'b0;

        // First tie after reset goes to CPU, then strict alternation
        req_i = 2'b11;
        #1 check("tie_first", 32'(gnt_o), 32'h1);
        wait_gnt(2'b10, "alt_1");
        wait_gnt(2'b01, "alt_2");
        wait_gnt(2'b10, "alt_3");
        wait_gnt(2'b01, "alt_4");
        wait_gnt(2'b10, "alt_5");

        // DMA wakes after CPU grant 3: CPU may keep one more grant
        do_reset();
        req_i = 2'b01;
        for (int k = 0; k < 3; k++) wait_gnt(2'b01, "h3_cpu");
        @(posedge clk); #1 req_i = 2'b11;
        wait_gnt(2'b01, "h3_keep");
        wait_gnt(2'b10, "h3_dma");

        // DMA wakes after CPU grant 7: hold 7 < 8 still allows one more
        do_reset();
        req_i = 2'b01;
        for (int k = 0; k < 7; k++) wait_gnt(2'b01, "h7_cpu");
        @(posedge clk); #1 req_i = 2'b11;
        wait_gnt(2'b01, "h7_keep");
        wait_gnt(2'b10, "h7_dma");

        // DMA wakes after CPU grant 8: hold saturated, DMA must win
        do_reset();
        req_i = 2'b01;
        for (int k = 0; k < 8; k++) wait_gnt(2'b01, "h8_cpu");
        @(posedge clk); #1 req_i = 2'b11;
        wait_gnt(2'b10, "h8_dma");

`ifdef ARB_STATS_EN
        do_reset();
        req_i = 2'b11;
        wait_gnt(2'b01, "st_tie_cpu");
        wait_gnt(2'b10, "st_tie_dma");
        @(posedge clk); #1 req_i = 2'b01;
        for (int k = 0; k < 4; k++) wait_gnt(2'b01, "st_cpu");
        @(posedge clk); #1 req_i = 2'b10;
        for (int k = 0; k < 2; k++) wait_gnt(2'b10, "st_dma");
        @(posedge clk); #1 req_i = 2'b00;
        repeat (3) @(negedge clk);
        check("st_cpu_cnt", 32'(stat_grants_o[0]), 32'd5);
        check("st_dma_cnt", 32'(stat_grants_o[1]), 32'd3);
        check("st_wait", 32'(stat_wait_o >= 16'd1), 32'd1);
`endif

        req_i = 2'b00;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
